// File: rtl/mem_addr_seq.sv
// Memory-address source selector with an exception-vector fetch sequencer (IDLE -> VEC -> CAP).
// Optional: define MEM_ADDR_SEQ_PENDING_EN to latch exception requests that arrive while busy.
module mem_addr_seq #(
  parameter int ADDR_W   = 32,
  parameter int NSRC     = 3,
  parameter int NEXC     = 3,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 1,
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int CW = (NEXC > 1) ? $clog2(NEXC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SW-1:0]          src_sel,
  input  logic [NSRC*ADDR_W-1:0] src_addr,
  input  logic [NEXC-1:0]        exc_req,
  input  logic [7:0]             mem_data_in,
  output logic [ADDR_W-1:0]      addr_out,
  output logic                   exc_busy,
  output logic                   exc_ack,
  output logic [CW-1:0]          exc_cause,
  output logic [ADDR_W-1:0]      vec_pc,
  output logic                   vec_valid
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    VEC,
    CAP
  } state_t;

  state_t          state;
  logic [LW-1:0]   cnt;
  logic [NEXC-1:0] req_eff;
  logic [CW-1:0]   win;

`ifdef MEM_ADDR_SEQ_PENDING_EN
  logic [NEXC-1:0] pend;
  logic [NEXC-1:0] win_mask;

  assign req_eff  = exc_req | pend;
  assign win_mask = NEXC'(1) << win;

  // Requests seen while busy are remembered; the accepted cause is dropped at acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else if (state == IDLE) begin
      if (|req_eff) pend <= req_eff & ~win_mask;
    end else begin
      pend <= pend | exc_req;
    end
  end
`else
  assign req_eff = exc_req;
`endif

  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    win = '0;
    for (int unsigned i = NEXC; i > 0; i--) begin
      if (req_eff[i-1]) win = CW'(i - 1);
    end
  end

  always_comb begin
    addr_out = '0;
    if (state == IDLE) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (src_sel == SW'(i)) addr_out = src_addr[i*ADDR_W +: ADDR_W];
      end
    end else begin
      addr_out = ADDR_W'(VEC_BASE) + ADDR_W'(exc_cause);
    end
  end

  assign exc_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      exc_ack   <= 1'b0;
      vec_valid <= 1'b0;
      exc_cause <= '0;
      vec_pc    <= '0;
    end else begin
      exc_ack   <= 1'b0;
      vec_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_eff) begin
            state     <= VEC;
            exc_cause <= win;
            exc_ack   <= 1'b1;
            cnt       <= LW'(MEM_LAT - 1);
          end
        end
        VEC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= CAP;
        end
        CAP: begin
          vec_pc    <= ADDR_W'(mem_data_in);
          vec_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_addr_seq.sv
// Bench for mem_addr_seq: two instances (MEM_LAT=1 and MEM_LAT=3) against a transaction-level model.
module tb_mem_addr_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  src_sel;
  logic [95:0] src_addr;
  logic [2:0]  exc_req;
  logic [7:0]  mem_data_in;

  logic [31:0] addr_o  [2];
  logic        busy_o  [2];
  logic        ack_o   [2];
  logic [1:0]  cause_o [2];
  logic [31:0] vpc_o   [2];
  logic        vv_o    [2];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          busy;
    int          cause;
    int          left;
    logic [31:0] vpc;
    bit          vv;
    bit          ack;
    bit [2:0]    pend;
  } mdl_t;

  mdl_t m [2];
  int   lat [2] = '{1, 3};

  always #5 clk = ~clk;

  mem_addr_seq #(.ADDR_W(32), .NSRC(3), .NEXC(3), .VEC_BASE(253), .MEM_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .src_sel(src_sel), .src_addr(src_addr), .exc_req(exc_req),
    .mem_data_in(mem_data_in), .addr_out(addr_o[0]), .exc_busy(busy_o[0]), .exc_ack(ack_o[0]),
    .exc_cause(cause_o[0]), .vec_pc(vpc_o[0]), .vec_valid(vv_o[0]));

  mem_addr_seq #(.ADDR_W(32), .NSRC(3), .NEXC(3), .VEC_BASE(253), .MEM_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .src_sel(src_sel), .src_addr(src_addr), .exc_req(exc_req),
    .mem_data_in(mem_data_in), .addr_out(addr_o[1]), .exc_busy(busy_o[1]), .exc_ack(ack_o[1]),
    .exc_cause(cause_o[1]), .vec_pc(vpc_o[1]), .vec_valid(vv_o[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m[i].busy = 0; m[i].left = 0; m[i].cause = 0; m[i].vpc = '0;
      m[i].vv = 0; m[i].ack = 0; m[i].pend = '0;
    end
  endtask

  // Sequence view: an accepted request keeps the unit busy for MEM_LAT+1 cycles,
  // and the byte on the bus at the last of those edges becomes vec_pc.
  task automatic mstep();
    bit [2:0] eff;
    if (!reset) begin
      mreset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m[i].ack = 0;
      m[i].vv  = 0;
      if (m[i].busy) begin
`ifdef MEM_ADDR_SEQ_PENDING_EN
        m[i].pend = m[i].pend | exc_req;
`endif
        m[i].left--;
        if (m[i].left == 0) begin
          m[i].vpc  = {24'd0, mem_data_in};
          m[i].vv   = 1;
          m[i].busy = 0;
        end
      end else begin
        eff = exc_req | m[i].pend;
        if (eff != 0) begin
          for (int b = 2; b >= 0; b--) if (eff[b]) m[i].cause = b;
          m[i].busy = 1;
          m[i].left = lat[i] + 1;
          m[i].ack  = 1;
`ifdef MEM_ADDR_SEQ_PENDING_EN
          m[i].pend = eff & ~(3'b001 << m[i].cause);
`endif
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_addr(input int i);
    if (m[i].busy) return 32'(253 + m[i].cause);
    if (src_sel < 2'd3) return src_addr[src_sel*32 +: 32];
    return 32'd0;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("addr_out[%0d]", i),  addr_o[i],        exp_addr(i));
      chk($sformatf("exc_busy[%0d]", i),  32'(busy_o[i]),   32'(m[i].busy));
      chk($sformatf("exc_ack[%0d]", i),   32'(ack_o[i]),    32'(m[i].ack));
      chk($sformatf("exc_cause[%0d]", i), 32'(cause_o[i]),  32'(m[i].cause));
      chk($sformatf("vec_pc[%0d]", i),    vpc_o[i],         m[i].vpc);
      chk($sformatf("vec_valid[%0d]", i), 32'(vv_o[i]),     32'(m[i].vv));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mstep();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    mreset();
    check_all();
  endtask

  bit seen;

  initial begin
    reset = 1'b0; src_sel = '0; src_addr = '0; exc_req = '0; mem_data_in = '0;
    mreset();
    @(negedge clk);
    check_all();
    cyc();
    reset = 1'b1;
    src_addr = {32'h300, 32'h200, 32'h100};
    exc_req = 3'b100;
    cyc();
    exc_req = '0;
    repeat (2) cyc();

    // 1: reset mid-run, then release; addr_out follows source 0 combinationally
    async_reset();
    chk("t1_busy", 32'(busy_o[1]), 32'd0);
    chk("t1_vpc", vpc_o[0], 32'd0);
    cyc();
    reset = 1'b1;
    src_sel = 2'd0;
    src_addr[31:0] = 32'h40;
    #1;
    chk("t1_addr", addr_o[0], 32'h40);
    cyc();

    // 2: other sources and an out-of-range select
    src_sel = 2'd1; #1; chk("t2_src1", addr_o[0], 32'h200);
    src_sel = 2'd2; #1; chk("t2_src2", addr_o[0], 32'h300);
    src_sel = 2'd3; #1; chk("t2_src3", addr_o[0], 32'h0);
    cyc();

    // 3: single request, MEM_LAT=1 timing
    mem_data_in = 8'h7C;
    exc_req = 3'b010;
    cyc();
    chk("t3_ack", 32'(ack_o[0]), 32'd1);
    chk("t3_addr_a", addr_o[0], 32'd254);
    exc_req = '0;
    cyc();
    chk("t3_addr_b", addr_o[0], 32'd254);
    chk("t3_vv_low", 32'(vv_o[0]), 32'd0);
    cyc();
    chk("t3_vv", 32'(vv_o[0]), 32'd1);
    chk("t3_vpc", vpc_o[0], 32'h7C);
    cyc();
    chk("t3_vv_pulse", 32'(vv_o[0]), 32'd0);
    repeat (4) cyc();

    // 4: simultaneous requests, lowest index first, remaining one served after
    exc_req = 3'b110;
    cyc();
    chk("t4_cause", 32'(cause_o[0]), 32'd1);
    chk("t4_addr254", addr_o[0], 32'd254);
    exc_req = 3'b100;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc();
      if (ack_o[0]) seen = 1;
    end
    chk("t4_second_ack", 32'(seen), 32'd1);
    chk("t4_addr255", addr_o[0], 32'd255);
    exc_req = '0;
    repeat (8) cyc();

    // 5: MEM_LAT=3 instance reset while waiting on memory
    mem_data_in = 8'hA5;
    exc_req = 3'b001;
    cyc();
    exc_req = '0;
    cyc();
    chk("t5_busy_before", 32'(busy_o[1]), 32'd1);
    async_reset();
    chk("t5_busy", 32'(busy_o[1]), 32'd0);
    chk("t5_vpc", vpc_o[1], 32'd0);
    repeat (2) cyc();
    chk("t5_no_vv", 32'(vv_o[1]), 32'd0);
    reset = 1'b1;
    repeat (2) cyc();

    // 6: one-cycle pulse while busy
    exc_req = 3'b010;
    cyc();
    exc_req = 3'b001;
    cyc();
    exc_req = '0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (busy_o[0] && addr_o[0] == 32'd253) seen = 1;
    end
`ifdef MEM_ADDR_SEQ_PENDING_EN
    chk("t6_pulse_serviced", 32'(seen), 32'd1);
`else
    chk("t6_pulse_dropped", 32'(seen), 32'd0);
`endif
    repeat (4) cyc();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      src_sel     = 2'($urandom_range(0, 3));
      src_addr    = {$urandom, $urandom, $urandom};
      exc_req     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      mem_data_in = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        cyc();
        reset = 1'b1;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
